// File: rtl/mem_wb_skid_stage_pkg.sv
// Shared definitions for the MEM->WB skid stage: default widths, writeback-select
// encodings and the occupancy states of the 2-entry skid buffer.
// Latency: n/a (definitions only). Backpressure: n/a.
package mem_wb_skid_stage_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int SEL_W_DEF   = 2;
    localparam int RADDR_W_DEF = 5;
    localparam int CNT_W_DEF   = 32;

    // Writeback source select encodings
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [1:0] WB_SEL_IMM = 2'b11;

    // Buffer occupancy: nothing held, main only, main + skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/mem_wb_skid_stage_if.sv
// Valid/ready handshake bundle carrying one MEM->WB entry.
// Latency: n/a (wires only). Backpressure: rdy flows from the slave back to the master.
// master drives vld + payload and samples rdy; slave samples vld + payload and drives rdy.
interface mem_wb_skid_stage_if
    import mem_wb_skid_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF
);
    logic               vld;
    logic               rdy;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    immediate;
    logic [XLEN-1:0]    pc_plus_4;
    logic [XLEN-1:0]    dmem_rdata;
    logic [SEL_W-1:0]   rd_dest_select;
    logic [RADDR_W-1:0] rd_addr;
    logic               reg_write;

    modport master (
        output vld, alu_result, immediate, pc_plus_4, dmem_rdata,
               rd_dest_select, rd_addr, reg_write,
        input  rdy
    );

    modport slave (
        input  vld, alu_result, immediate, pc_plus_4, dmem_rdata,
               rd_dest_select, rd_addr, reg_write,
        output rdy
    );
endinterface

// File: rtl/mem_wb_skid_stage_skid_buf.sv
// Generic 2-entry skid buffer over a packed W-bit payload, with flush.
// Latency: 1 cycle from accept to out_vld when empty.
// Backpressure: in_rdy = state != FULL, purely registered (no path from out_rdy).
// Ports: clk/rst, flush, in_vld/in_rdy/in_dat (upstream), out_vld/out_rdy/out_dat (downstream).
module mem_wb_skid_stage_skid_buf
    import mem_wb_skid_stage_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept, release_e;

    assign in_rdy    = (state_q != ST_FULL);
    assign out_vld   = (state_q != ST_EMPTY);
    assign out_dat   = main_q;
    assign accept    = in_vld && in_rdy;
    assign release_e = out_vld && out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_dat;
                end
            end
            ST_ONE: begin
                if (accept && release_e) begin
                    main_d = in_dat;
                end else if (accept) begin
                    // head is stuck; the newcomer waits behind it
                    state_d = ST_FULL;
                    skid_d  = in_dat;
                end else if (release_e) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (release_e) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // flush overrides everything, including a same-cycle accept
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline stage: packs the writeback entry into a 2-entry skid buffer, counts stalls.
// Latency: 1 cycle input-to-output when empty; full throughput with downstream ready.
// Backpressure: up.rdy drops only when both entries are held; stall_cycles saturates.
// Ports: clk, rst (sync, active-high), i_flush, up (slave, from MEM), dn (master, to WB),
//        o_stall_cycles (cycles with dn.vld && !dn.rdy, cleared only by rst).
module mem_wb_skid_stage
    import mem_wb_skid_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    mem_wb_skid_stage_if.slave   up,
    mem_wb_skid_stage_if.master  dn,
    output logic [CNT_W-1:0]     o_stall_cycles
);

    localparam int W = 4 * XLEN + SEL_W + RADDR_W + 1;

    logic [W-1:0]     in_dat;
    logic [W-1:0]     out_dat;
    logic [CNT_W-1:0] stall_q;

    assign in_dat = {up.alu_result, up.immediate, up.pc_plus_4, up.dmem_rdata,
                     up.rd_dest_select, up.rd_addr, up.reg_write};

    assign {dn.alu_result, dn.immediate, dn.pc_plus_4, dn.dmem_rdata,
            dn.rd_dest_select, dn.rd_addr, dn.reg_write} = out_dat;

    mem_wb_skid_stage_skid_buf #(.W(W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush   (i_flush),
        .in_vld  (up.vld),
        .in_rdy  (up.rdy),
        .in_dat  (in_dat),
        .out_vld (dn.vld),
        .out_rdy (dn.rdy),
        .out_dat (out_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (dn.vld && !dn.rdy && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Self-checking bench: two stage instances (32-bit and 4-bit stall counters) driven identically,
// compared each cycle against a queue-based model of a 2-deep in-order buffer.
module tb_mem_wb_skid_stage;
    import mem_wb_skid_stage_pkg::*;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [31:0] rdata;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] stall32;
    logic [3:0]  stall4;

    int checks = 0;
    int errors = 0;

    // reference model state
    pkt_t        mq[$];
    logic        zero_out = 1'b1;
    int unsigned cnt32 = 0;
    int unsigned cnt4  = 0;

    mem_wb_skid_stage_if up  ();
    mem_wb_skid_stage_if dn  ();
    mem_wb_skid_stage_if up2 ();
    mem_wb_skid_stage_if dn2 ();

    always #5 clk = ~clk;

    mem_wb_skid_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .i_flush(flush), .up(up), .dn(dn), .o_stall_cycles(stall32)
    );

    mem_wb_skid_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .i_flush(flush), .up(up2), .dn(dn2), .o_stall_cycles(stall4)
    );

    assign up2.vld            = up.vld;
    assign up2.alu_result     = up.alu_result;
    assign up2.immediate      = up.immediate;
    assign up2.pc_plus_4      = up.pc_plus_4;
    assign up2.dmem_rdata     = up.dmem_rdata;
    assign up2.rd_dest_select = up.rd_dest_select;
    assign up2.rd_addr        = up.rd_addr;
    assign up2.reg_write      = up.reg_write;
    assign dn2.rdy            = dn.rdy;

    function automatic pkt_t dn_pkt();
        return '{dn.alu_result, dn.immediate, dn.pc_plus_4, dn.dmem_rdata,
                 dn.rd_dest_select, dn.rd_addr, dn.reg_write};
    endfunction

    function automatic pkt_t dn2_pkt();
        return '{dn2.alu_result, dn2.immediate, dn2.pc_plus_4, dn2.dmem_rdata,
                 dn2.rd_dest_select, dn2.rd_addr, dn2.reg_write};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("o_valid", {159'd0, dn.vld}, {159'd0, mq.size() > 0});
        chk("o_ready", {159'd0, up.rdy}, {159'd0, mq.size() < 2});
        chk("stall_cycles", {128'd0, stall32}, {128'd0, cnt32});
        chk("o_valid_sat", {159'd0, dn2.vld}, {159'd0, mq.size() > 0});
        chk("stall_cycles_sat", {156'd0, stall4}, {128'd0, cnt4});
        if (mq.size() > 0) begin
            chk("payload", {24'd0, dn_pkt()}, {24'd0, mq[0]});
            chk("payload_sat", {24'd0, dn2_pkt()}, {24'd0, mq[0]});
        end else if (zero_out) begin
            chk("payload_zero", {24'd0, dn_pkt()}, 160'd0);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then check after it.
    task automatic tick(input bit v, input bit r, input bit f, input bit rs,
                        input bit force_alu, input logic [31:0] alu_val);
        pkt_t e;
        bit   acc, rel;
        e.alu   = force_alu ? alu_val : $urandom;
        e.imm   = $urandom;
        e.pc4   = $urandom;
        e.rdata = $urandom;
        e.sel   = 2'($urandom_range(0, 3));
        e.rd    = 5'($urandom_range(0, 31));
        e.we    = 1'($urandom_range(0, 1));
        up.vld            = v;
        up.alu_result     = e.alu;
        up.immediate      = e.imm;
        up.pc_plus_4      = e.pc4;
        up.dmem_rdata     = e.rdata;
        up.rd_dest_select = e.sel;
        up.rd_addr        = e.rd;
        up.reg_write      = e.we;
        dn.rdy            = r;
        flush             = f;
        rst               = rs;

        acc = v && (mq.size() < 2);
        rel = (mq.size() > 0) && r;
        if (rs) begin
            mq.delete();
            cnt32    = 0;
            cnt4     = 0;
            zero_out = 1'b1;
        end else begin
            if ((mq.size() > 0) && !r) begin
                if (cnt32 < 32'hFFFF_FFFF) cnt32++;
                if (cnt4 < 15) cnt4++;
            end
            if (f) begin
                mq.delete();
                zero_out = 1'b1;
            end else begin
                if (rel) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back(e);
                    zero_out = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        up.vld = 1'b0;
        dn.rdy = 1'b0;

        // reset held 3 cycles with upstream valid
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 0, 0);

        // streaming: 8 back-to-back entries
        for (int i = 0; i < 8; i++) tick(1, 1, 0, 0, 1, 32'h10 + i);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);

        // backpressure: A then B with downstream stalled, then drain
        tick(1, 0, 0, 0, 1, 32'hAAAA_0000);
        tick(1, 0, 0, 0, 1, 32'hBBBB_0000);
        tick(1, 0, 0, 0, 1, 32'hDEAD_0000);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);

        // flush while FULL, with C offered in the same cycle
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 1, 0, 1, 32'h0000_CCCC);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);

        // simultaneous accept and release: stays in ONE at full rate
        for (int i = 0; i < 12; i++) tick(1, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);

        // saturation of the 4-bit counter
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0, 0, 0);
        end

        // reset mid-operation discards held entries
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 1, 1, 0, 0);
        tick(0, 1, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
